adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL provide parameter STAGES, default 2, pipeline depth; legal 1..4, WIDTH divisible by STAGES, else elaboration error.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port iSA  input  3  mode: [0] 0=add/1=sub, [1] 0=unsigned/1=signed, [2] 1=saturate.
REQ-006 SHALL have port iData_a  input  WIDTH  operand a.
REQ-007 SHALL have port iData_b  input  WIDTH  operand b.
REQ-008 SHALL have port iValid  input  1  operands and iSA valid this cycle.
REQ-009 SHALL have port oReady  output  1  block accepts input this cycle.
REQ-010 SHALL have port oData  output  WIDTH  result.
REQ-011 SHALL have port oValid  output  1  oData/flags valid.
REQ-012 SHALL have port iReady  input  1  downstream accepts result.
REQ-013 SHALL have ports carry, negative, overflow, zero  output  1 each  result flags, registered with oData.

Function
REQ-014 SHALL accept a transfer when iValid && oReady; oReady = iReady || !oValid (global stall).
REQ-015 SHALL, when stalled (oValid && !iReady), hold every pipeline register including oData, flags, oValid unchanged.
REQ-016 SHALL present the result exactly STAGES unstalled cycles after acceptance; one result per cycle sustained; order preserved.
REQ-017 SHALL split the carry chain into STAGES slices of WIDTH/STAGES bits, stage k adding slice k with registered carry from stage k-1; upper operand slices and mode bits travel with the data.
REQ-018 SHALL compute sub as a + ~b + 1 (carry-in 1 at slice 0).
REQ-019 SHALL set carry, unsigned add: carry-out of MSB; unsigned sub: borrow (1 iff a < b unsigned); signed modes: 0.
REQ-020 SHALL set overflow, signed modes: carry-in(MSB) XOR carry-out(MSB); unsigned modes: 0.
REQ-021 SHALL set negative = MSB of final oData in signed modes; 0 in unsigned modes.
REQ-022 SHALL set zero = 1 iff final oData is all zeros, all modes.
REQ-023 SHALL, with iSA[2]=1, clamp: unsigned add carry -> all ones; unsigned sub borrow -> 0; signed overflow -> 0111..1 if true result positive, 1000..0 if negative; no clamp otherwise.
REQ-024 SHALL report carry/overflow from the raw (pre-clamp) operation even when clamped.
REQ-025 SHALL, with iSA[2]=0, wrap modulo 2^WIDTH.
REQ-026 SHALL, for STAGES=1, register result after one cycle with identical flag rules.
REQ-027 SHALL keep oData and flags unchanged while oValid=0 (last value held, bubbles do not alter outputs).
REQ-028 SHALL infer no latches; every flag defined in every mode.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear all stage valid bits, oValid, oData, carry, negative, overflow, zero to 0.
REQ-030 SHALL discard all in-flight operations on reset mid-operation; none emerge afterwards.
REQ-031 SHALL drive oReady=1 during and after reset (oValid=0); input presented while rst=1 is not accepted.
REQ-032 SHALL have rst take priority over stall and accept in the same cycle.

Verification (WIDTH=32, STAGES=2)
REQ-033 Unsigned add FFFF_FFFF+0000_0001, iSA=000 -> 2 cycles later oData=0, carry=1, zero=1; iSA=100 -> oData=FFFF_FFFF, carry=1, zero=0.
REQ-034 Unsigned sub 0000_0003-0000_0005, iSA=001 -> oData=FFFF_FFFE, carry=1; iSA=101 -> oData=0, carry=1, zero=1.
REQ-035 Signed add 7FFF_FFFF+1, iSA=010 -> oData=8000_0000, overflow=1, negative=1; iSA=110 -> oData=7FFF_FFFF, overflow=1, negative=0; signed sub 8000_0000-1, iSA=111 -> 8000_0000, overflow=1.
REQ-036 Back-to-back 4 operations with iReady=1 -> 4 results on consecutive cycles, in order; then iReady=0 for 3 cycles with 2 in flight -> oReady=0, oData/oValid frozen, nothing lost on release.
REQ-037 Carry across slice boundary 0000_FFFF+0000_0001, iSA=000 -> 0001_0000, carry=0, overflow=0.
REQ-038 rst asserted one cycle after two acceptances -> next cycle oValid=0, all outputs 0, no stale result ever appears.

Source files
------------

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
// Pipelined add/subtract unit with a carry chain split into STAGES slices.
// Each stage adds one WIDTH/STAGES-bit slice and hands its carry-out to the
// next stage through a register. Supports unsigned/signed add/sub with
// optional saturation. The whole pipe stalls globally when the output holds
// a result that downstream has not taken.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   iSA[2:0] : mode, [0] 0=add/1=sub, [1] 0=unsigned/1=signed, [2] saturate
//   iData_a  : operand a
//   iData_b  : operand b
//   iValid   : operands and iSA valid this cycle
//   oReady   : block accepts input this cycle (iReady || !oValid)
//   oData    : result
//   oValid   : oData and flags valid
//   iReady   : downstream accepts the result
//   carry, negative, overflow, zero : result flags, registered with oData
// -----------------------------------------------------------------------------
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       iSA,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic             iValid,
    output logic             oReady,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    input  logic             iReady,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             zero
);

    localparam int SL   = WIDTH / STAGES;
    localparam int NREG = (STAGES > 1) ? (STAGES - 1) : 1;

    if ((WIDTH < 8) || (WIDTH > 64) || (STAGES < 1) || (STAGES > 4) ||
        ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("adder_pipe: illegal WIDTH/STAGES combination");
    end

    // Intermediate stage registers (between slice adders)
    logic             v_q    [NREG];
    logic [2:0]       mode_q [NREG];
    logic [WIDTH-1:0] a_q    [NREG];
    logic [WIDTH-1:0] b_q    [NREG];   // b already inverted for subtraction
    logic [WIDTH-1:0] sum_q  [NREG];   // lower slices already computed
    logic             c_q    [NREG];   // carry into the next slice

    // Per-stage combinational inputs
    logic             st_v_s    [STAGES];
    logic [2:0]       st_mode_s [STAGES];
    logic [WIDTH-1:0] st_a_s    [STAGES];
    logic [WIDTH-1:0] st_b_s    [STAGES];
    logic [WIDTH-1:0] st_sum_s  [STAGES];
    logic             st_cin_s  [STAGES];

    // Final-stage results feeding the output register
    logic             fin_v_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             fin_carry_s;
    logic             fin_neg_s;
    logic             fin_ovf_s;
    logic             fin_zero_s;

    // Output registers
    logic             ovalid_q;
    logic [WIDTH-1:0] odata_q;
    logic             carry_q;
    logic             neg_q;
    logic             ovf_q;
    logic             zero_q;

    // Global advance: the pipe moves unless a held result is being refused
    logic advance_s;
    assign advance_s = iReady || !ovalid_q;

    assign oReady   = advance_s;
    assign oValid   = ovalid_q;
    assign oData    = odata_q;
    assign carry    = carry_q;
    assign negative = neg_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        logic [SL:0]      part_s;
        logic [WIDTH-1:0] sum_n_s;

        if (s == 0) begin : g_in
            assign st_v_s[s]    = iValid;
            assign st_mode_s[s] = iSA;
            assign st_a_s[s]    = iData_a;
            assign st_b_s[s]    = iSA[0] ? ~iData_b : iData_b;
            assign st_sum_s[s]  = {WIDTH{1'b0}};
            assign st_cin_s[s]  = iSA[0];   // +1 of two's complement subtract
        end else begin : g_fwd
            assign st_v_s[s]    = v_q[s-1];
            assign st_mode_s[s] = mode_q[s-1];
            assign st_a_s[s]    = a_q[s-1];
            assign st_b_s[s]    = b_q[s-1];
            assign st_sum_s[s]  = sum_q[s-1];
            assign st_cin_s[s]  = c_q[s-1];
        end

        assign part_s = {1'b0, st_a_s[s][s*SL +: SL]}
                      + {1'b0, st_b_s[s][s*SL +: SL]}
                      + {{SL{1'b0}}, st_cin_s[s]};

        // Merge this stage's slice into the partially built sum
        always_comb begin
            sum_n_s = st_sum_s[s];
            sum_n_s[s*SL +: SL] = part_s[SL-1:0];
        end

        if (s < STAGES - 1) begin : g_reg
            // Stage register: carries operands, mode, partial sum and carry
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q[s]    <= 1'b0;
                    mode_q[s] <= 3'b000;
                    a_q[s]    <= {WIDTH{1'b0}};
                    b_q[s]    <= {WIDTH{1'b0}};
                    sum_q[s]  <= {WIDTH{1'b0}};
                    c_q[s]    <= 1'b0;
                end else if (advance_s) begin
                    v_q[s]    <= st_v_s[s];
                    mode_q[s] <= st_mode_s[s];
                    a_q[s]    <= st_a_s[s];
                    b_q[s]    <= st_b_s[s];
                    sum_q[s]  <= sum_n_s;
                    c_q[s]    <= part_s[SL];
                end else begin
                    v_q[s]    <= v_q[s];
                    mode_q[s] <= mode_q[s];
                    a_q[s]    <= a_q[s];
                    b_q[s]    <= b_q[s];
                    sum_q[s]  <= sum_q[s];
                    c_q[s]    <= c_q[s];
                end
            end
        end else begin : g_fin
            logic cout_s;
            logic ovf_raw_s;

            assign fin_v_s = st_v_s[s];

            // Flags from the raw result, then optional clamp
            always_comb begin
                cout_s      = part_s[SL];
                // carry into the MSB recovered from the MSB sum bit
                ovf_raw_s   = (st_a_s[s][WIDTH-1] ^ st_b_s[s][WIDTH-1] ^
                               sum_n_s[WIDTH-1]) ^ cout_s;
                fin_res_s   = sum_n_s;
                fin_carry_s = 1'b0;
                fin_ovf_s   = 1'b0;
                if (st_mode_s[s][1]) begin
                    fin_ovf_s = ovf_raw_s;
                    if (st_mode_s[s][2] && ovf_raw_s) begin
                        // raw MSB set on overflow means the true result is positive
                        if (sum_n_s[WIDTH-1]) begin
                            fin_res_s = {1'b0, {(WIDTH-1){1'b1}}};
                        end else begin
                            fin_res_s = {1'b1, {(WIDTH-1){1'b0}}};
                        end
                    end else begin
                        fin_res_s = sum_n_s;
                    end
                end else if (st_mode_s[s][0]) begin
                    fin_carry_s = ~cout_s;   // borrow
                    if (st_mode_s[s][2] && !cout_s) begin
                        fin_res_s = {WIDTH{1'b0}};
                    end else begin
                        fin_res_s = sum_n_s;
                    end
                end else begin
                    fin_carry_s = cout_s;
                    if (st_mode_s[s][2] && cout_s) begin
                        fin_res_s = {WIDTH{1'b1}};
                    end else begin
                        fin_res_s = sum_n_s;
                    end
                end
                fin_neg_s  = st_mode_s[s][1] ? fin_res_s[WIDTH-1] : 1'b0;
                fin_zero_s = (fin_res_s == {WIDTH{1'b0}});
            end
        end
    end

    // Output register: bubbles advance oValid but leave data and flags alone
    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid_q <= 1'b0;
            odata_q  <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (advance_s) begin
            ovalid_q <= fin_v_s;
            if (fin_v_s) begin
                odata_q <= fin_res_s;
                carry_q <= fin_carry_s;
                neg_q   <= fin_neg_s;
                ovf_q   <= fin_ovf_s;
                zero_q  <= fin_zero_s;
            end else begin
                odata_q <= odata_q;
                carry_q <= carry_q;
                neg_q   <= neg_q;
                ovf_q   <= ovf_q;
                zero_q  <= zero_q;
            end
        end else begin
            ovalid_q <= ovalid_q;
            odata_q  <= odata_q;
            carry_q  <= carry_q;
            neg_q    <= neg_q;
            ovf_q    <= ovf_q;
            zero_q   <= zero_q;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
// Self-checking bench for adder_pipe (WIDTH=32, STAGES=2). A behavioural
// model (arithmetic reference plus a STAGES-deep delay line that freezes on
// stall) is checked every cycle; directed vectors, stall and reset sequences
// and a randomized run drive it.
// -----------------------------------------------------------------------------
module tb_adder_pipe;
    localparam int W  = 32;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   iSA;
    logic [W-1:0] iData_a;
    logic [W-1:0] iData_b;
    logic         iValid;
    logic         oReady;
    logic [W-1:0] oData;
    logic         oValid;
    logic         iReady;
    logic         carry;
    logic         negative;
    logic         overflow;
    logic         zero;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst), .iSA(iSA), .iData_a(iData_a), .iData_b(iData_b),
        .iValid(iValid), .oReady(oReady), .oData(oData), .oValid(oValid),
        .iReady(iReady), .carry(carry), .negative(negative),
        .overflow(overflow), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         c;
        logic         n;
        logic         o;
        logic         z;
    } res_t;

    typedef struct packed {
        logic v;
        res_t r;
    } slot_t;

    typedef struct {
        logic [2:0]   m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         exp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    slot_t dl [ST];     // dl[ST-1] is what the output register should hold
    res_t  last;        // last valid result, held through bubbles

    function automatic res_t ref_op(input logic [2:0] m, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        res_t   r;
        logic [W:0] u;
        longint sa, sb, t, maxs, mins;
        r.c  = 1'b0;
        r.o  = 1'b0;
        maxs = (longint'(1) <<< (W-1)) - 1;
        mins = -(longint'(1) <<< (W-1));
        if (!m[1]) begin
            if (!m[0]) begin
                u   = {1'b0, a} + {1'b0, b};
                r.c = u[W];
                r.d = (m[2] && r.c) ? {W{1'b1}} : u[W-1:0];
            end else begin
                r.c = (a < b);
                r.d = (m[2] && r.c) ? {W{1'b0}} : (a - b);
            end
        end else begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            t   = m[0] ? (sa - sb) : (sa + sb);
            r.o = (t > maxs) || (t < mins);
            if (m[2] && r.o) r.d = (t > 0) ? maxs[W-1:0] : mins[W-1:0];
            else             r.d = t[W-1:0];
        end
        r.n = m[1] ? r.d[W-1] : 1'b0;
        r.z = (r.d == {W{1'b0}});
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ST; i++) dl[i] = '0;
        last = '0;
    endtask

    // One clock cycle: apply inputs, check outputs vs model, clock, update model
    task automatic cycle(input logic r, input logic v, input logic [2:0] m,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rd);
        logic exp_rdy;
        rst = r; iValid = v; iSA = m; iData_a = a; iData_b = b; iReady = rd;
        #1;
        exp_rdy = rd || !dl[ST-1].v;
        chk("oReady", 64'(oReady), 64'(exp_rdy));
        chk("oValid", 64'(oValid), 64'(dl[ST-1].v));
        chk("result", 64'({oData, carry, negative, overflow, zero}), 64'(last));
        @(posedge clk);
        #1;
        if (r) begin
            model_clear();
        end else if (exp_rdy) begin
            for (int i = ST-1; i > 0; i--) dl[i] = dl[i-1];
            dl[0].v = v;
            dl[0].r = ref_op(m, a, b);
            if (dl[ST-1].v) last = dl[ST-1].r;
        end
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[1]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[2]  = '{3'b001, 32'h0000_0003, 32'h0000_0005, '{32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{3'b101, 32'h0000_0003, 32'h0000_0005, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[5]  = '{3'b110, 32'h7FFF_FFFF, 32'h0000_0001, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[6]  = '{3'b111, 32'h8000_0000, 32'h0000_0001, '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[7]  = '{3'b000, 32'h0000_FFFF, 32'h0000_0001, '{32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{3'b011, 32'h0000_0005, 32'h0000_0005, '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[9]  = '{3'b001, 32'h0000_0005, 32'h0000_0003, '{32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[11] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0}};

        model_clear();
        rst = 1'b1; iValid = 1'b0; iSA = 3'b000; iData_a = '0; iData_b = '0; iReady = 1'b1;
        @(posedge clk);
        #1;
        // reset state, with input presented during reset (must not be accepted)
        cycle(1'b1, 1'b1, 3'b000, 32'h1234_5678, 32'h1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);

        // Directed vectors: issue, wait one more edge, compare to table
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, vecs[i].m, vecs[i].a, vecs[i].b, 1'b1);
            cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
            chk($sformatf("vec%0d_valid", i), 64'(oValid), 64'd1);
            chk($sformatf("vec%0d_out", i), 64'({oData, carry, negative, overflow, zero}),
                64'(vecs[i].exp));
            cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        end

        // Back-to-back four operations
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 3'(i), 32'h1000_0000 * (i + 1), 32'h0100_0001 * i, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);

        // Stall with two in flight: output frozen on 0x30, second op waits
        cycle(1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_0020, 1'b1);
        cycle(1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'h0000_0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 3'b000, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
            chk("stall_ready", 64'(oReady), 64'd0);
            chk("stall_hold", 64'(oData), 64'h30);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);

        // Reset one cycle after two acceptances
        cycle(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_0002, 1'b1);
        cycle(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_0004, 1'b1);
        cycle(1'b1, 1'b1, 3'b000, 32'h0000_0005, 32'h0000_0006, 1'b1);
        chk("rst_outputs", 64'({oValid, oData, carry, negative, overflow, zero}), 64'd0);
        chk("rst_ready", 64'(oReady), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);

        // Randomized traffic with corner operands, random stalls and resets
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] a, b;
            int sel;
            sel = $urandom_range(0, 4);
            a   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF :
                  (sel == 2) ? 32'h7FFF_FFFF : (sel == 3) ? 32'h8000_0000 : 32'($urandom);
            sel = $urandom_range(0, 4);
            b   = (sel == 0) ? 32'h1 : (sel == 1) ? 32'hFFFF_FFFF :
                  (sel == 2) ? 32'h8000_0000 : 32'($urandom);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), a, b, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
